biquad_tdm_sequencer: RTL

Time-multiplexed controller that evaluates a cascade of NUM_SECTIONS DF2T biquad sections with a single shared multiplier and accumulator. It accepts one input sample through a valid/ready handshake and steps each section through five multiply cycles. It forwards each section's output to the next section and emits one filtered sample per accepted input. Coefficients are written into a shadow bank over a configuration port and copied into the active bank only at sample boundaries, so a running filter never mixes coefficient sets within one sample.

---
 rtl/biquad_tdm_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/biquad_tdm_sequencer.sv
// Cascade of DF2T biquad sections evaluated with one shared multiplier (five products
// per section); a shadow coefficient bank is copied into the active bank between samples.
module biquad_tdm_sequencer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned COEFF_WIDTH  = 16,
  parameter int unsigned FRAC_BITS    = 14,
  parameter int unsigned NUM_SECTIONS = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [DATA_WIDTH-1:0]      x_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic signed [DATA_WIDTH-1:0]      y_out,
  output logic                              out_valid,
  input  logic                              cfg_we,
  input  logic [$clog2(5*NUM_SECTIONS)-1:0] cfg_addr,
  input  logic signed [COEFF_WIDTH-1:0]     cfg_data,
  input  logic                              cfg_commit,
  output logic                              busy
);
  localparam int unsigned NCOEF  = 5 * NUM_SECTIONS;
  localparam int unsigned ADDR_W = $clog2(NCOEF);
  localparam int unsigned SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int unsigned PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int unsigned ACC_W  = DATA_WIDTH + COEFF_WIDTH + 3;
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NUM_SECTIONS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(64'sd1 <<< FRAC_BITS);

  typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_APPLY} state_e;

  state_e           state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [2:0]       ph_q, ph_d;
  logic             pending_q;
  logic             accept, do_apply, sample_done, compute_en;

  logic signed [COEFF_WIDTH-1:0] shadow_q [NCOEF];
  logic signed [COEFF_WIDTH-1:0] active_q [NCOEF];
  logic signed [DATA_WIDTH-1:0]  s1_q [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  s2_q [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  v_q, y_q, y_out_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic                          out_valid_q;

  logic [ADDR_W-1:0]             coef_idx;
  logic [2:0]                    coef_k;
  logic signed [COEFF_WIDTH-1:0] coef;
  logic signed [DATA_WIDTH-1:0]  mul_in;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       state_term, sum;
  logic signed [DATA_WIDTH-1:0]  sum_sat;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] val);
    if (val > SAT_MAX) return DATA_WIDTH'(SAT_MAX);
    if (val < ~SAT_MAX) return DATA_WIDTH'(~SAT_MAX);
    return DATA_WIDTH'(val);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      ph_q    <= ph_d;
    end
  end

  // A pending commit is applied straight after the last product, so in_ready returns one cycle late.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    ph_d    = ph_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d = ST_APPLY;
        end else if (in_valid) begin
          state_d = ST_COMPUTE;
          sec_d   = '0;
          ph_d    = '0;
        end
      end
      ST_COMPUTE: begin
        if (ph_q == 3'd4) begin
          ph_d = '0;
          if (sec_q == LAST_SEC) state_d = pending_q ? ST_APPLY : ST_IDLE;
          else                   sec_d   = sec_q + SEC_W'(1);
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    do_apply    = 1'b0;
    sample_done = 1'b0;
    compute_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !pending_q;
        busy     = pending_q;
        accept   = in_valid && !pending_q;
      end
      ST_COMPUTE: begin
        compute_en  = 1'b1;
        sample_done = (ph_q == 3'd4) && (sec_q == LAST_SEC);
      end
      ST_APPLY: do_apply = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= (i % 5 == 0) ? UNITY : '0;
        active_q[i] <= (i % 5 == 0) ? UNITY : '0;
      end
    end else begin
      pending_q <= cfg_commit || (pending_q && !do_apply);
      for (int i = 0; i < NCOEF; i++) begin
        if (cfg_we && cfg_addr == ADDR_W'(i)) shadow_q[i] <= cfg_data;
        if (do_apply) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Phase order b0, b1, a1, b2, a2; the a-terms multiply y and subtract from acc.
  always_comb begin
    coef_k     = ph_q;
    state_term = '0;
    mul_in     = v_q;
    case (ph_q)
      3'd0: state_term = ACC_W'(s1_q[sec_q]) <<< FRAC_BITS;
      3'd1: state_term = ACC_W'(s2_q[sec_q]) <<< FRAC_BITS;
      3'd2: begin
        coef_k = 3'd3;
        mul_in = y_q;
      end
      3'd3: coef_k = 3'd2;
      3'd4: mul_in = y_q;
      default: ;
    endcase
    coef_idx = ADDR_W'(5 * int'(sec_q)) + ADDR_W'(coef_k);
    coef     = active_q[coef_idx];
    prod     = PROD_W'(coef) * PROD_W'(mul_in);
    if (ph_q == 3'd2 || ph_q == 3'd4) sum = acc_q - ACC_W'(prod);
    else                              sum = state_term + ACC_W'(prod);
    sum_sat  = sat(sum >>> FRAC_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        s1_q[s] <= '0;
        s2_q[s] <= '0;
      end
    end else begin
      out_valid_q <= sample_done;
      if (sample_done) y_out_q <= y_q;
      if (accept) v_q <= x_in;
      if (compute_en) begin
        case (ph_q)
          3'd0: begin
            acc_q <= sum;
            y_q   <= sum_sat;
          end
          3'd1, 3'd3: acc_q <= sum;
          3'd2: s1_q[sec_q] <= sum_sat;
          3'd4: begin
            s2_q[sec_q] <= sum_sat;
            v_q         <= y_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign y_out     = y_out_q;
  assign out_valid = out_valid_q;

endmodule
